bit_deserializer: RTL and testbench
===================================

# bit_deserializer

Bit-serial to parallel collector that sits directly downstream of the single-bit passthrough stage. It consumes that stage's 1-bit output as a serial stream qualified by a valid/ready handshake. It packs WIDTH accepted bits into a word and presents the word on a held output register with a valid/ack handshake. Backpressure from the word side propagates to the bit side, so no bit is ever dropped.

## Interface
- WIDTH, 8, number of bits per assembled word (≥2)
- MSB_FIRST, 1, 1: first accepted bit lands in word_out[WIDTH-1]; 0: first accepted bit lands in word_out[0]
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- bit_in  input  1  serial data bit (driven by upstream Aout)
- bit_valid  input  1  bit_in carries a bit this cycle
- bit_ready  output  1  deserializer can accept a bit this cycle
- word_out  output  WIDTH  last completed word, held stable while word_valid=1
- word_valid  output  1  word_out holds an unconsumed word
- word_ack  input  1  consumer takes word_out this cycle (ignored when word_valid=0)
- bit_count  output  $clog2(WIDTH)+1  bits currently held in the shift register, 0..WIDTH

## Operation
- A bit is accepted on a rising edge where bit_valid=1 and bit_ready=1. It is ignored otherwise.
- Shift register fill order:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
- bit_count increments by 1 per accepted bit.
- Collector FSM has two states:
  - COLLECT: bit_ready=1, bit_count < WIDTH.
  - FULL: bit_ready=0, bit_count = WIDTH, shift register holds a complete word.
- The output slot is free in a cycle when word_valid=0, or when word_valid=1 and word_ack=1.
- COLLECT, accepting the WIDTH-th bit, slot free:
  - word_out takes the completed word and word_valid=1.
  - bit_count=0 and the FSM stays in COLLECT.
- COLLECT, accepting the WIDTH-th bit, slot not free:
  - The FSM goes to FULL with bit_count=WIDTH.
  - word_out and word_valid are unchanged.
- FULL, slot free:
  - The word transfers to word_out and word_valid=1.
  - bit_count=0 and the FSM returns to COLLECT.
- FULL, slot not free: everything holds.
- word_ack with word_valid=1 and no transfer that edge: word_valid=0 and word_out holds its last value.
- word_ack with word_valid=0 has no effect.
- Reset, on any edge with reset=1, regardless of other inputs:
  - FSM=COLLECT, bit_count=0, shift register=0, word_out=0, word_valid=0.
  - bit_ready=1 after that edge.
  - A bit or ack presented on a reset edge is discarded.
  - A partially collected word is lost.
- bit_ready is a decode of FSM state only. There is no combinational path from word_ack or bit_valid to bit_ready.
- word_out and word_valid are registered outputs.

## Timing
- Latency: word_valid=1 and word_out are updated in the cycle immediately after the edge that accepts the WIDTH-th bit, when the slot is free.
- Throughput: with word_ack held at 1, one bit is accepted per cycle with no bubbles. One word completes every WIDTH cycles.
- Last bit and ack on the same edge: word_valid stays 1 and word_out changes directly to the new word, with no low cycle.
- Backpressure: bit_ready drops in the cycle after the WIDTH-th bit is accepted while the slot is occupied.
  - In FULL, word_ack on an edge causes word_out to change to the new word after that edge.
  - bit_ready=1 in the following cycle, so at most one bit slot is lost per ack.
- Gaps: cycles with bit_valid=0 leave bit_count and the shift register unchanged. Words are built from accepted bits only.
- Reset mid-word: bit_count reads 0 the cycle after the reset edge. The next WIDTH accepted bits form a clean word.

## Test plan
- Reset: reset=1 for 2 cycles with bit_valid=1, bit_in=1, word_ack=1 → word_out=0, word_valid=0, bit_count=0, bit_ready=1 after release.
- Back-to-back MSB-first, WIDTH=8, word_ack=1: feed 1,0,1,1,0,0,1,0 on consecutive cycles → word_out=8'hB2 and word_valid=1 exactly one cycle after the 8th bit, bit_count=0.
- Gapped input: the same bits with bit_valid low on alternate cycles and bit_in toggling during the gaps → word_out=8'hB2, bit_count steps 1..7 only on accepted bits.
- Backpressure: with 8'hB2 held unacked, feed 0,1,0,1,1,0,1,0:
  - bit_ready=0 and bit_count=8 the cycle after the 8th bit; word_out stays 8'hB2.
  - Pulse word_ack → word_out=8'h5A, word_valid=1, then bit_ready=1 the next cycle.
- Simultaneous last bit and ack: second word's 8th bit accepted on the same edge as word_ack → word_valid never drops, word_out goes 8'hB2 → 8'h5A.
- LSB-first and mid-word reset: with MSB_FIRST=0, feed 1,0,1,1,0,0,1,0 → word_out=8'h4D. Then feed 5 bits, reset for 1 cycle, feed 1,0,1,1,0,0,1,0 → bit_count=0 after reset, word_out=8'h4D.

Source files
------------

// File: rtl/bit_deserializer.sv
// bit_deserializer: packs a bit-serial stream into WIDTH-bit words.
// Bits arrive on a valid/ready handshake. Finished words leave on a held
// register with a valid/ack handshake. When the word register is occupied,
// the collector parks one complete word and stalls the bit side, so no bit
// is ever dropped.
//
// Handshake semantics:
//   bit side  - a bit transfers on a rising edge where bit_valid=1 and
//               bit_ready=1. bit_ready depends only on the registered FSM
//               state, never combinationally on bit_valid or word_ack.
//   word side - word_out/word_valid are registers. word_out is held stable
//               while word_valid=1. A word is consumed on an edge where
//               word_valid=1 and word_ack=1. word_ack is ignored while
//               word_valid=0.
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [WIDTH-1:0]       word_out,
    output logic                   word_valid,
    input  logic                   word_ack,
    output logic [$clog2(WIDTH):0] bit_count
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // COLLECT: accepting bits. FULL: a complete word is parked in the shift
    // register, waiting for the output register to free up.
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] word_q;
    logic             word_valid_q;

    logic slot_free;
    logic accept;
    logic last_bit;

    // The output slot can take a new word if it is empty or is being consumed now.
    assign slot_free = !word_valid_q || word_ack;
    assign accept    = bit_valid && (state_q == COLLECT);
    assign last_bit  = (count_q == LAST_CNT);

    assign bit_ready  = (state_q == COLLECT);
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign bit_count  = count_q;

    // Next shift-register contents if the current bit is accepted.
    always_comb begin
        shift_d = shift_q;
        if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], bit_in};
        end else begin
            shift_d = {bit_in, shift_q[WIDTH-1:1]};
        end
    end

    // Collector FSM with its registered outputs: shift register, count and word slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            shift_q      <= '0;
            count_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            // Consumption empties the slot unless a transfer below refills it.
            if (word_valid_q && word_ack) begin
                word_valid_q <= 1'b0;
            end

            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shift_q <= shift_d;
                        if (last_bit) begin
                            if (slot_free) begin
                                word_q       <= shift_d;
                                word_valid_q <= 1'b1;
                                count_q      <= '0;
                            end else begin
                                count_q <= FULL_CNT;
                                state_q <= FULL;
                            end
                        end else begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        word_q       <= shift_q;
                        word_valid_q <= 1'b1;
                        count_q      <= '0;
                        state_q      <= COLLECT;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer. Two instances (MSB-first and LSB-first) share
// one stimulus stream; each has its own expected-word queue.
module tb_bit_deserializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset     = 1'b1;
    logic bit_in    = 1'b0;
    logic bit_valid = 1'b0;
    logic word_ack  = 1'b0;

    logic       bit_ready_m, word_valid_m, bit_ready_l, word_valid_l;
    logic [7:0] word_out_m, word_out_l;
    logic [3:0] bit_count_m, bit_count_l;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_m), .word_out(word_out_m), .word_valid(word_valid_m),
        .word_ack(word_ack), .bit_count(bit_count_m)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_l), .word_out(word_out_l), .word_valid(word_valid_l),
        .word_ack(word_ack), .bit_count(bit_count_l)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0] exp_m_q[$];
    logic [7:0] exp_l_q[$];

    // Bench model of bit collection: accepted bits in arrival order.
    logic acc_bits[8];
    int   acc_n     = 0;
    logic model_rdy = 1'b0;

    typedef struct {
        logic       v;
        logic       b;
        logic       a;
        logic [3:0] cnt;
        logic       rdy;
        logic       wv;
    } vec_t;

    vec_t vecs[40];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Positional packing: i-th accepted bit goes to bit 7-i (MSB-first) or bit i (LSB-first).
    task automatic model_accept(input logic b);
        logic [7:0] wm;
        logic [7:0] wl;
        if (model_rdy) begin
            acc_bits[acc_n] = b;
            acc_n++;
            if (acc_n == 8) begin
                for (int i = 0; i < 8; i++) begin
                    wm[7-i] = acc_bits[i];
                    wl[i]   = acc_bits[i];
                end
                exp_m_q.push_back(wm);
                exp_l_q.push_back(wl);
                acc_n = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic b, input logic a);
        bit_valid = v;
        bit_in    = b;
        word_ack  = a;
        if (v && !reset) model_accept(b);
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic v, input logic b, input logic a,
                           input int cnt, input logic rdy, input logic wv);
        vecs[i].v   = v;
        vecs[i].b   = b;
        vecs[i].a   = a;
        vecs[i].cnt = 4'(cnt);
        vecs[i].rdy = rdy;
        vecs[i].wv  = wv;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].v, vecs[i].b, vecs[i].a);
            model_rdy = vecs[i].rdy;
            chk($sformatf("row%0d_cnt_m", i), 32'(bit_count_m), 32'(vecs[i].cnt));
            chk($sformatf("row%0d_cnt_l", i), 32'(bit_count_l), 32'(vecs[i].cnt));
            chk($sformatf("row%0d_rdy_m", i), 32'(bit_ready_m), 32'(vecs[i].rdy));
            chk($sformatf("row%0d_rdy_l", i), 32'(bit_ready_l), 32'(vecs[i].rdy));
            chk($sformatf("row%0d_wv_m", i), 32'(word_valid_m), 32'(vecs[i].wv));
            chk($sformatf("row%0d_wv_l", i), 32'(word_valid_l), 32'(vecs[i].wv));
        end
    endtask

    // ---------------- scoreboard ----------------
    // A new word is on the output when word_valid is high now and, in the
    // previous cycle, it was low or the word was being acknowledged.
    logic pv_m = 1'b0;
    logic pv_l = 1'b0;
    logic pa   = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            pv_m = 1'b0;
            pv_l = 1'b0;
            pa   = 1'b0;
        end else begin
            if (word_valid_m === 1'b1 && (!pv_m || pa)) begin
                if (exp_m_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_m: got unexpected word %0h expected none", word_out_m);
                end else begin
                    chk("word_m", 32'(word_out_m), 32'(exp_m_q.pop_front()));
                end
            end
            if (word_valid_l === 1'b1 && (!pv_l || pa)) begin
                if (exp_l_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_l: got unexpected word %0h expected none", word_out_l);
                end else begin
                    chk("word_l", 32'(word_out_l), 32'(exp_l_q.pop_front()));
                end
            end
            pv_m = (word_valid_m === 1'b1);
            pv_l = (word_valid_l === 1'b1);
            pa   = (word_ack === 1'b1);
        end
    end

    // ---------------- test ----------------
    initial begin
        logic [7:0] bits_a;
        logic [7:0] bits_c;
        bits_a = 8'b1011_0010;
        bits_c = 8'b0101_1010;

        // A: back-to-back, ack held high.
        for (int i = 0; i < 8; i++)
            set_row(i, 1'b1, bits_a[7-i], 1'b1, (i == 7) ? 0 : i + 1, 1'b1, i == 7);
        // B: gapped, bit_in toggling during the idle cycles; word left unacked.
        for (int k = 0; k < 8; k++) begin
            set_row(8 + 2*k, 1'b1, bits_a[7-k], 1'b0, (k == 7) ? 0 : k + 1, 1'b1, k == 7);
            set_row(9 + 2*k, 1'b0, ~bits_a[7-k], 1'b0, (k == 7) ? 0 : k + 1, 1'b1, k == 7);
        end
        // C: backpressure, previous word held unacked.
        for (int i = 0; i < 8; i++)
            set_row(24 + i, 1'b1, bits_c[7-i], 1'b0, i + 1, i != 7, 1'b1);
        // D: last bit and ack on the same edge.
        for (int i = 0; i < 8; i++)
            set_row(32 + i, 1'b1, bits_a[7-i], i == 7, (i == 7) ? 0 : i + 1, 1'b1, 1'b1);

        // Reset with traffic presented on the reset edges.
        reset = 1'b1;
        model_rdy = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        acc_n = 0;
        model_rdy = 1'b1;
        chk("rst_wo_m", 32'(word_out_m), 32'h0);
        chk("rst_wo_l", 32'(word_out_l), 32'h0);
        chk("rst_wv_m", 32'(word_valid_m), 32'h0);
        chk("rst_cnt_m", 32'(bit_count_m), 32'h0);
        chk("rst_rdy_m", 32'(bit_ready_m), 32'h1);

        apply_rows(0, 7);
        chk("a_wo_m", 32'(word_out_m), 32'hB2);
        chk("a_wo_l", 32'(word_out_l), 32'h4D);

        // Ack with no transfer: valid drops, data holds.
        drive(1'b0, 1'b0, 1'b1);
        chk("ack_wv_m", 32'(word_valid_m), 32'h0);
        chk("ack_wo_m", 32'(word_out_m), 32'hB2);

        apply_rows(8, 23);
        chk("b_wo_m", 32'(word_out_m), 32'hB2);
        chk("b_wo_l", 32'(word_out_l), 32'h4D);

        apply_rows(24, 31);
        // Stalled in FULL: an offered bit is ignored and everything holds.
        drive(1'b1, 1'b1, 1'b0);
        chk("full_cnt_m", 32'(bit_count_m), 32'h8);
        chk("full_rdy_m", 32'(bit_ready_m), 32'h0);
        chk("full_wo_m", 32'(word_out_m), 32'hB2);
        chk("full_wv_m", 32'(word_valid_m), 32'h1);
        // Ack releases the parked word; bit side reopens after that edge.
        drive(1'b1, 1'b1, 1'b1);
        model_rdy = 1'b1;
        chk("rel_wo_m", 32'(word_out_m), 32'h5A);
        chk("rel_wo_l", 32'(word_out_l), 32'h5A);
        chk("rel_wv_m", 32'(word_valid_m), 32'h1);
        chk("rel_rdy_m", 32'(bit_ready_m), 32'h1);
        chk("rel_cnt_m", 32'(bit_count_m), 32'h0);

        apply_rows(32, 39);
        chk("d_wo_m", 32'(word_out_m), 32'hB2);
        chk("d_wo_l", 32'(word_out_l), 32'h4D);

        // Mid-word reset: first bit's ack drains the held word, then 5 bits, then reset.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("mid_cnt_m", 32'(bit_count_m), 32'h5);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        acc_n = 0;
        chk("mrst_cnt_m", 32'(bit_count_m), 32'h0);
        chk("mrst_cnt_l", 32'(bit_count_l), 32'h0);
        chk("mrst_rdy_l", 32'(bit_ready_l), 32'h1);
        chk("mrst_wv_l", 32'(word_valid_l), 32'h0);
        chk("mrst_wo_l", 32'(word_out_l), 32'h0);
        for (int i = 0; i < 8; i++) drive(1'b1, bits_a[7-i], 1'b0);
        bit_valid = 1'b0;
        chk("e_wv_l", 32'(word_valid_l), 32'h1);
        chk("e_wo_l", 32'(word_out_l), 32'h4D);
        chk("e_wo_m", 32'(word_out_m), 32'hB2);

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("queue_m_left", 32'(exp_m_q.size()), 32'h0);
        chk("queue_l_left", 32'(exp_l_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
